// File: rtl/led_fade_pwm_if.sv
// led_fade_pwm_if: sequencer-to-LED-stage bundle carrying level strobes in and PWM pins out
// Signals:
//   load         - single-cycle strobe qualifying level_in
//   level_in     - packed levels, channel j at [j*LEVEL_BITS +: LEVEL_BITS]
//   LED          - registered PWM outputs, 1 = lit
//   frame_start  - one-cycle pulse at each PWM frame boundary
// Modports: master drives levels (sequencer/bench), slave is the fade/PWM stage.
interface led_fade_pwm_if #(
    parameter int CHANNELS   = 8,
    parameter int LEVEL_BITS = 4
);
    logic                           load;
    logic [CHANNELS*LEVEL_BITS-1:0] level_in;
    logic [CHANNELS-1:0]            LED;
    logic                           frame_start;
    modport master (output load, level_in, input LED, frame_start);
    modport slave (input load, level_in, output LED, frame_start);
endinterface

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: per-channel peak-hold levels with tick-driven fade, rendered as glitch-free PWM
// Optional feature macro: FADE_GAMMA_EN (6-bit gamma-corrected PWM instead of 4-bit linear)
// Ports:
//   oneMHzClock      - sole clock, rising edge
//   reset            - asynchronous active-high, clears all state and forces LED low
//   bus.load         - single-cycle strobe qualifying bus.level_in
//   bus.level_in     - packed levels, channel j at [j*LEVEL_BITS +: LEVEL_BITS]
//   bus.LED          - registered PWM outputs, 1 = lit
//   bus.frame_start  - one-cycle pulse on the cycle the shadow compare values load
module led_fade_pwm #(
    parameter int CHANNELS   = 8,
    parameter int LEVEL_BITS = 4,
    parameter int TICK_BITS  = 12
) (
    input logic           oneMHzClock,
    input logic           reset,
    led_fade_pwm_if.slave bus
);
`ifdef FADE_GAMMA_EN
    localparam int DUTY_BITS = LEVEL_BITS + 2;
    // Perceptual brightness curve for 4-bit levels onto a 64-step frame.
    localparam int GAMMA [16] = '{0, 1, 2, 3, 4, 6, 8, 10, 13, 16, 20, 25, 31, 38, 47, 63};
`else
    localparam int DUTY_BITS = LEVEL_BITS;
`endif
    typedef logic [LEVEL_BITS-1:0] lvl_t;
    typedef logic [DUTY_BITS-1:0] duty_t;

    logic [TICK_BITS-1:0] presc_q, presc_d;
    duty_t                duty_q, duty_d;
    lvl_t [CHANNELS-1:0]  lvl_q, lvl_d, dec, lin;
    duty_t [CHANNELS-1:0] sh_q, sh_d;
    logic [CHANNELS-1:0]  led_q, led_d;
    logic                 fs_q;
    logic                 tick, frame;

    function automatic duty_t cmp_val(input lvl_t l);
`ifdef FADE_GAMMA_EN
        return duty_t'(GAMMA[l]);
`else
        return l;
`endif
    endfunction

    always_comb begin
        tick    = presc_q == '1;
        frame   = duty_q == '1;
        presc_d = presc_q + TICK_BITS'(1);
        duty_d  = duty_q + DUTY_BITS'(1);
        for (int j = 0; j < CHANNELS; j++) begin
            lin[j]   = bus.level_in[j*LEVEL_BITS +: LEVEL_BITS];
            // Decay happens before the peak-hold max, so a reload of the same level survives a tick.
            dec[j]   = (tick && lvl_q[j] != '0) ? lvl_q[j] - lvl_t'(1) : lvl_q[j];
            lvl_d[j] = (bus.load && lin[j] > dec[j]) ? lin[j] : dec[j];
            // Shadow only changes at the wrap, so each frame renders one compare value.
            sh_d[j]  = frame ? cmp_val(lvl_q[j]) : sh_q[j];
            led_d[j] = duty_q < sh_q[j];
        end
    end

    always_ff @(posedge oneMHzClock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            duty_q  <= '0;
            lvl_q   <= '0;
            sh_q    <= '0;
            led_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            duty_q  <= duty_d;
            lvl_q   <= lvl_d;
            sh_q    <= sh_d;
            led_q   <= led_d;
            fs_q    <= frame;
        end
    end

    assign bus.LED         = led_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_led_fade_pwm.sv
// tb_led_fade_pwm: randomized scoreboard bench for led_fade_pwm against a time-indexed level model
module tb_led_fade_pwm;
    localparam int CH = 8;
    localparam int LB = 4;
    localparam int TB = 12;
    localparam int W  = CH * LB;
    localparam int T  = 1 << TB;
`ifdef FADE_GAMMA_EN
    localparam int F = 64;
    localparam int GAMMA [16] = '{0, 1, 2, 3, 4, 6, 8, 10, 13, 16, 20, 25, 31, 38, 47, 63};
`else
    localparam int F = 16;
`endif
    typedef logic [CH-1:0][7:0] shv_t;

    logic oneMHzClock = 1'b0;
    logic reset = 1'b0;
    led_fade_pwm_if #(.CHANNELS(CH), .LEVEL_BITS(LB)) bus();
    led_fade_pwm #(.CHANNELS(CH), .LEVEL_BITS(LB), .TICK_BITS(TB)) dut (
        .oneMHzClock(oneMHzClock),
        .reset(reset),
        .bus(bus)
    );

    always #5 oneMHzClock = ~oneMHzClock;

    int   vectors = 0;
    int   errors = 0;
    int   lvl [CH];
    int   n = 0;
    shv_t expq [$];
    shv_t cur = '0;
    int   p = 0;
    int   cnt = 0;

    function automatic int cmp_val(input int l);
`ifdef FADE_GAMMA_EN
        return GAMMA[l];
`else
        return l;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: edge n of the run sees prescaler n mod T and duty n mod F.
    task automatic step(input logic ld, input logic [W-1:0] v);
        shv_t s;
        int   d;
        bus.load = ld;
        bus.level_in = v;
        if (n % F == F - 1) begin
            for (int j = 0; j < CH; j++) s[j] = 8'(cmp_val(lvl[j]));
            expq.push_back(s);
        end
        for (int j = 0; j < CH; j++) begin
            d = lvl[j];
            if (n % T == T - 1 && d > 0) d = d - 1;
            if (ld && int'(v[j*LB +: LB]) > d) d = int'(v[j*LB +: LB]);
            lvl[j] = d;
        end
        n++;
        @(negedge oneMHzClock);
    endtask

    task automatic mid_reset();
        @(posedge oneMHzClock);
        #3;
        reset = 1'b1;
        bus.load = 1'b1;
        bus.level_in = '1;
        #1;
        check("async_reset_led", bus.LED, 0);
        check("async_reset_fs", bus.frame_start, 0);
        expq.delete();
        for (int j = 0; j < CH; j++) lvl[j] = 0;
        n = 0;
        repeat (2) @(negedge oneMHzClock);
        reset = 1'b0;
        bus.load = 1'b0;
    endtask

    always @(posedge oneMHzClock) begin
        logic [CH-1:0] e;
        #1;
        if (reset) begin
            cur = '0;
            p = 0;
            cnt = 0;
        end else begin
            for (int j = 0; j < CH; j++) e[j] = p < int'(cur[j]);
            check("led", bus.LED, e);
            p = (p + 1) % F;
            cnt++;
            if (bus.frame_start) begin
                check("frame_period", cnt, F);
                cnt = 0;
                if (expq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_frame at %0t: got frame_start=1 expected no boundary", $time);
                end else cur = expq.pop_front();
            end else if (cnt > F) begin
                vectors++;
                errors++;
                $display("FAIL frame_missing at %0t: got %0d cycles without frame_start expected %0d", $time, cnt, F);
                cnt = 0;
            end
        end
    end

    initial begin
        bus.load = 1'b0;
        bus.level_in = '0;
        for (int j = 0; j < CH; j++) lvl[j] = 0;
        #1 reset = 1'b1;
        #1;
        check("reset_led", bus.LED, 0);
        check("reset_fs", bus.frame_start, 0);
        repeat (2) @(negedge oneMHzClock);
        reset = 1'b0;
        repeat (40) step(1'b0, '0);
        step(1'b1, {CH{LB'(8)}});
        repeat (40) step(1'b0, '0);
        step(1'b1, W'(32'h0000_000F));
        repeat (2) step(1'b0, '0);
        step(1'b1, W'(32'h0000_0004));
        repeat (40) step(1'b0, '0);
        step(1'b1, W'(32'h0000_0300));
        while (n % T != T - 2) step(1'b0, '0);
        step(1'b1, W'(32'h0000_0050));
        step(1'b1, W'(32'h0000_0050));
        while (n % T != T - 2) step(1'b0, '0);
        step(1'b1, W'(32'h0000_0060));
        step(1'b1, W'(32'h0000_0050));
        repeat (4 * T + 40) step(1'b0, '0);
        for (int i = 0; i < 6000; i++) step($urandom_range(0, 7) == 0, W'($urandom));
        step(1'b1, '1);
        repeat (2 * F) step(1'b0, '0);
        while (n % F != 5) step(1'b0, '0);
        mid_reset();
        repeat (3 * F) step(1'b0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
